// File: rtl/lpif_asym_pkg.sv
// Shared definitions for the LPIF asymmetric sync gate: FSM state
// encodings, delay counter width, strobe pulse period and a saturating
// increment helper used by every counter in the block.
package lpif_asym_pkg;

    localparam int DLY_W            = 16;
    localparam int STB_PULSE_PERIOD = 16;
    localparam int STB_PH_W         = $clog2(STB_PULSE_PERIOD);

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_WAIT   = 2'd1,
        TX_ONLINE = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_WAIT   = 2'd1,
        RX_HOLD   = 2'd2,
        RX_ONLINE = 2'd3
    } rx_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DLY_W-1:0] sat_inc(input logic [DLY_W-1:0] v);
        return (v == {DLY_W{1'b1}}) ? v : v + {{(DLY_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/lpif_asym_dly_cnt.sv
// Saturating delay counter: cleared by clr, counts while en, and flags
// match whenever the current count equals limit. Saturation keeps a
// limit of 16'hFFFF reachable and holds match once it is reached.
module lpif_asym_dly_cnt
    import lpif_asym_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DLY_W-1:0] limit,
    output logic             match
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match = (cnt_q == limit);

endmodule

// File: rtl/lpif_asym_sync_gate.sv
// LPIF asymmetric sync gate. A TX FSM and an RX FSM each wait a
// programmable number of cycles after their link request before opening
// the downstream / upstream valid gates. Marker and strobe user bits are
// generated from the TX FSM. Data registers capture only lanes whose
// gated valid is set.
// Optional feature: define LPIF_ASYM_SYNC_DROP_CNT_EN to count cycles in
// which valid traffic arrived while its direction was gated; otherwise the
// count field of debug_status is constant zero.
module lpif_asym_sync_gate
    import lpif_asym_pkg::*;
#(
    parameter int NUM_CH            = 2,
    parameter int RATIO             = 4,
    parameter int LANE_W            = 128,
    parameter int PERSISTENT_STROBE = 1
) (
    input  logic                            clk_wr,
    input  logic                            rst_wr,
    input  logic                            tx_online,
    input  logic                            rx_online,
    input  logic                            rx_online_holdoff,
    input  logic [DLY_W-1:0]                delay_x_value,
    input  logic [DLY_W-1:0]                delay_y_value,
    input  logic [DLY_W-1:0]                delay_z_value,
    input  logic [NUM_CH*RATIO*LANE_W-1:0]  dstrm_data,
    input  logic [RATIO-1:0]                dstrm_valid,
    output logic [NUM_CH*RATIO*LANE_W-1:0]  txg_data,
    output logic [RATIO-1:0]                txg_valid,
    input  logic [NUM_CH*RATIO*LANE_W-1:0]  rxp_data,
    input  logic [RATIO-1:0]                rxp_valid,
    output logic [NUM_CH*RATIO*LANE_W-1:0]  ustrm_data,
    output logic [RATIO-1:0]                ustrm_valid,
    output logic [RATIO-1:0]                tx_auto_mrk_userbit,
    output logic                            tx_auto_stb_userbit,
    output logic                            tx_online_delay,
    output logic                            rx_online_delay,
    output logic [31:0]                     debug_status
);

    localparam int DW = NUM_CH * RATIO * LANE_W;

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;

    logic                tx_online_delay_q, tx_online_delay_d;
    logic                rx_online_delay_q, rx_online_delay_d;
    logic [RATIO-1:0]    mrk_q, mrk_d;
    logic                stb_armed_q, stb_armed_d;
    logic [STB_PH_W-1:0] stb_phase_q, stb_phase_d;
    logic                stb_live;

    logic [RATIO-1:0]    txg_valid_q, txg_valid_d;
    logic [RATIO-1:0]    ustrm_valid_q, ustrm_valid_d;
    logic [DW-1:0]       txg_data_q, txg_data_d;
    logic [DW-1:0]       ustrm_data_q, ustrm_data_d;

    logic                x_match, y_match, z_match;
    logic [DLY_W-1:0]    cnt;

    // X counts TX_WAIT cycles, Y counts RX_WAIT cycles, Z counts cycles
    // since TX_WAIT entry for the strobe start.
    lpif_asym_dly_cnt u_dly_x (
        .clk   (clk_wr),
        .rst   (rst_wr),
        .clr   (tx_state_q != TX_WAIT),
        .en    (tx_state_q == TX_WAIT),
        .limit (delay_x_value),
        .match (x_match)
    );

    lpif_asym_dly_cnt u_dly_y (
        .clk   (clk_wr),
        .rst   (rst_wr),
        .clr   (rx_state_q != RX_WAIT),
        .en    (rx_state_q == RX_WAIT),
        .limit (delay_y_value),
        .match (y_match)
    );

    lpif_asym_dly_cnt u_dly_z (
        .clk   (clk_wr),
        .rst   (rst_wr),
        .clr   (tx_state_q == TX_IDLE),
        .en    (tx_state_q != TX_IDLE),
        .limit (delay_z_value),
        .match (z_match)
    );

    // TX next state: dropping tx_online wins over every other transition.
    always_comb begin
        tx_state_d = tx_state_q;
        if (!tx_online) begin
            tx_state_d = TX_IDLE;
        end else begin
            case (tx_state_q)
                TX_IDLE:   tx_state_d = TX_WAIT;
                TX_WAIT:   if (x_match) tx_state_d = TX_ONLINE;
                TX_ONLINE: tx_state_d = TX_ONLINE;
                default:   tx_state_d = TX_IDLE;
            endcase
        end
    end

    // RX next state: holdoff toggles between HOLD and ONLINE once the wait is done.
    always_comb begin
        rx_state_d = rx_state_q;
        if (!rx_online) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE:   rx_state_d = RX_WAIT;
                RX_WAIT:   if (y_match) rx_state_d = RX_HOLD;
                RX_HOLD:   if (!rx_online_holdoff) rx_state_d = RX_ONLINE;
                RX_ONLINE: if (rx_online_holdoff) rx_state_d = RX_HOLD;
                default:   rx_state_d = RX_IDLE;
            endcase
        end
    end

    // Registered FSM outputs and strobe sequencing derived from next/current state.
    always_comb begin
        tx_online_delay_d      = (tx_state_d == TX_ONLINE);
        rx_online_delay_d      = (rx_state_d == RX_ONLINE);
        mrk_d                  = '0;
        mrk_d[RATIO-1]         = (tx_state_d != TX_IDLE);
        // Strobe is live from the Z match onward; the phase counts from the
        // match so that phase zero marks each periodic pulse.
        stb_live    = (tx_state_q != TX_IDLE) && (stb_armed_q || z_match);
        stb_armed_d = stb_live;
        if (tx_state_q == TX_IDLE) begin
            stb_phase_d = '0;
        end else if (stb_live) begin
            stb_phase_d = stb_phase_q + {{(STB_PH_W-1){1'b0}}, 1'b1};
        end else begin
            stb_phase_d = stb_phase_q;
        end
    end

    // Gated valids and lane-wise data capture; lanes without a gated valid hold.
    always_comb begin
        txg_valid_d   = tx_online_delay_q ? dstrm_valid : '0;
        ustrm_valid_d = rx_online_delay_q ? rxp_valid   : '0;
        txg_data_d    = txg_data_q;
        ustrm_data_d  = ustrm_data_q;
        for (int r = 0; r < RATIO; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (txg_valid_d[r]) begin
                    txg_data_d[(c*RATIO+r)*LANE_W +: LANE_W] = dstrm_data[(c*RATIO+r)*LANE_W +: LANE_W];
                end
                if (ustrm_valid_d[r]) begin
                    ustrm_data_d[(c*RATIO+r)*LANE_W +: LANE_W] = rxp_data[(c*RATIO+r)*LANE_W +: LANE_W];
                end
            end
        end
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            tx_state_q        <= TX_IDLE;
            rx_state_q        <= RX_IDLE;
            tx_online_delay_q <= 1'b0;
            rx_online_delay_q <= 1'b0;
            mrk_q             <= '0;
            stb_armed_q       <= 1'b0;
            stb_phase_q       <= '0;
        end else begin
            tx_state_q        <= tx_state_d;
            rx_state_q        <= rx_state_d;
            tx_online_delay_q <= tx_online_delay_d;
            rx_online_delay_q <= rx_online_delay_d;
            mrk_q             <= mrk_d;
            stb_armed_q       <= stb_armed_d;
            stb_phase_q       <= stb_phase_d;
        end
    end

    // Gated data path registers; cleared on reset so outputs read zero.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            txg_valid_q   <= '0;
            ustrm_valid_q <= '0;
            txg_data_q    <= '0;
            ustrm_data_q  <= '0;
        end else begin
            txg_valid_q   <= txg_valid_d;
            ustrm_valid_q <= ustrm_valid_d;
            txg_data_q    <= txg_data_d;
            ustrm_data_q  <= ustrm_data_d;
        end
    end

`ifdef LPIF_ASYM_SYNC_DROP_CNT_EN
    logic [DLY_W-1:0] drop_cnt_q, drop_cnt_d;

    // Count cycles where traffic was offered into a closed gate.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (((|dstrm_valid) && !tx_online_delay_q) || ((|rxp_valid) && !rx_online_delay_q)) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // Drop counter register; only reset clears it.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign cnt = drop_cnt_q;
`else
    assign cnt = '0;
`endif

    assign tx_online_delay     = tx_online_delay_q;
    assign rx_online_delay     = rx_online_delay_q;
    assign tx_auto_mrk_userbit = mrk_q;
    assign tx_auto_stb_userbit = stb_live && ((PERSISTENT_STROBE != 0) || (stb_phase_q == '0));
    assign txg_valid           = txg_valid_q;
    assign txg_data            = txg_data_q;
    assign ustrm_valid         = ustrm_valid_q;
    assign ustrm_data          = ustrm_data_q;
    assign debug_status        = {12'h000, tx_online_delay_q, rx_online_delay_q, 2'b00, cnt};

endmodule

// File: tb/tb_lpif_asym_sync_gate.sv
// Bench for lpif_asym_sync_gate. Two instances share the control inputs:
// A uses the default geometry with persistent strobe, B is NUM_CH=1,
// RATIO=1 with the periodic strobe. A run-length model predicts every
// output each cycle; directed checks pin the model with literal values.
// Honours LPIF_ASYM_SYNC_DROP_CNT_EN when defined.
module tb_lpif_asym_sync_gate;

    localparam int A_CH = 2;
    localparam int A_R  = 4;
    localparam int A_W  = 128;
    localparam int A_DW = A_CH * A_R * A_W;
    localparam int B_W  = 16;

    logic clk = 1'b0;
    logic rst;
    logic tx_online, rx_online, holdoff;
    logic [15:0] dx, dy, dz;

    logic [A_DW-1:0] dd_a, rd_a, txd_a, usd_a;
    logic [A_R-1:0]  dv_a, rv_a, txv_a, usv_a, mrk_a;
    logic            stb_a, txod_a, rxod_a;
    logic [31:0]     dbg_a;

    logic [B_W-1:0]  dd_b, rd_b, txd_b, usd_b;
    logic [0:0]      dv_b, rv_b, txv_b, usv_b, mrk_b;
    logic            stb_b, txod_b, rxod_b;
    logic [31:0]     dbg_b;

    int n_vec;
    int n_err;

    // Model state
    int              m_tx_run, m_rx_run;
    logic            m_txod, m_rxod, p_txod, p_rxod;
    logic [A_DW-1:0] e_txd_a, e_usd_a;
    logic [A_R-1:0]  e_txv_a, e_usv_a;
    logic [B_W-1:0]  e_txd_b, e_usd_b;
    logic [0:0]      e_txv_b, e_usv_b;
    logic [15:0]     e_cnt_a, e_cnt_b;

    always #5 clk = ~clk;

    lpif_asym_sync_gate #(.NUM_CH(A_CH), .RATIO(A_R), .LANE_W(A_W), .PERSISTENT_STROBE(1)) dut_a (
        .clk_wr(clk), .rst_wr(rst), .tx_online(tx_online), .rx_online(rx_online),
        .rx_online_holdoff(holdoff), .delay_x_value(dx), .delay_y_value(dy), .delay_z_value(dz),
        .dstrm_data(dd_a), .dstrm_valid(dv_a), .txg_data(txd_a), .txg_valid(txv_a),
        .rxp_data(rd_a), .rxp_valid(rv_a), .ustrm_data(usd_a), .ustrm_valid(usv_a),
        .tx_auto_mrk_userbit(mrk_a), .tx_auto_stb_userbit(stb_a),
        .tx_online_delay(txod_a), .rx_online_delay(rxod_a), .debug_status(dbg_a)
    );

    lpif_asym_sync_gate #(.NUM_CH(1), .RATIO(1), .LANE_W(B_W), .PERSISTENT_STROBE(0)) dut_b (
        .clk_wr(clk), .rst_wr(rst), .tx_online(tx_online), .rx_online(rx_online),
        .rx_online_holdoff(holdoff), .delay_x_value(dx), .delay_y_value(dy), .delay_z_value(dz),
        .dstrm_data(dd_b), .dstrm_valid(dv_b), .txg_data(txd_b), .txg_valid(txv_b),
        .rxp_data(rd_b), .rxp_valid(rv_b), .ustrm_data(usd_b), .ustrm_valid(usv_b),
        .tx_auto_mrk_userbit(mrk_b), .tx_auto_stb_userbit(stb_b),
        .tx_online_delay(txod_b), .rx_online_delay(rxod_b), .debug_status(dbg_b)
    );

    // Model: TX is online once tx_online has been sampled high on dx+2
    // consecutive edges; RX is online once rx_online has been high on dy+3
    // consecutive edges and holdoff was low at the latest edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tx_run = 0; m_rx_run = 0; m_txod = 1'b0; m_rxod = 1'b0;
            e_txd_a = '0; e_usd_a = '0; e_txv_a = '0; e_usv_a = '0;
            e_txd_b = '0; e_usd_b = '0; e_txv_b = '0; e_usv_b = '0;
            e_cnt_a = '0; e_cnt_b = '0;
        end else begin
            p_txod = m_txod;
            p_rxod = m_rxod;
            m_tx_run = tx_online ? m_tx_run + 1 : 0;
            m_rx_run = rx_online ? m_rx_run + 1 : 0;
            m_txod = (m_tx_run >= int'(dx) + 2);
            m_rxod = (m_rx_run >= int'(dy) + 3) && !holdoff;
            e_txv_a = p_txod ? dv_a : '0;
            e_usv_a = p_rxod ? rv_a : '0;
            e_txv_b = p_txod ? dv_b : '0;
            e_usv_b = p_rxod ? rv_b : '0;
            for (int w = 0; w < A_CH * A_R; w++) begin
                if (e_txv_a[w % A_R]) e_txd_a[w*A_W +: A_W] = dd_a[w*A_W +: A_W];
                if (e_usv_a[w % A_R]) e_usd_a[w*A_W +: A_W] = rd_a[w*A_W +: A_W];
            end
            if (e_txv_b[0]) e_txd_b = dd_b;
            if (e_usv_b[0]) e_usd_b = rd_b;
            if ((((|dv_a) && !p_txod) || ((|rv_a) && !p_rxod)) && e_cnt_a != 16'hFFFF) e_cnt_a = e_cnt_a + 16'd1;
            if (((dv_b[0] && !p_txod) || (rv_b[0] && !p_rxod)) && e_cnt_b != 16'hFFFF) e_cnt_b = e_cnt_b + 16'd1;
        end
    end

    function automatic logic exp_stb(input int run, input int z, input bit persist);
        int k;
        k = run - 1;
        if (run < 1 || k < z) return 1'b0;
        return persist ? 1'b1 : (((k - z) % 16) == 0);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [15:0] ca, cb;
`ifdef LPIF_ASYM_SYNC_DROP_CNT_EN
        ca = e_cnt_a; cb = e_cnt_b;
`else
        ca = 16'd0; cb = 16'd0;
`endif
        chk("mrk_a", 128'(mrk_a), 128'((m_tx_run >= 1) ? 4'b1000 : 4'b0000));
        chk("mrk_b", 128'(mrk_b), 128'(m_tx_run >= 1));
        chk("stb_a", 128'(stb_a), 128'(exp_stb(m_tx_run, int'(dz), 1'b1)));
        chk("stb_b", 128'(stb_b), 128'(exp_stb(m_tx_run, int'(dz), 1'b0)));
        chk("txod_a", 128'(txod_a), 128'(m_txod));
        chk("rxod_a", 128'(rxod_a), 128'(m_rxod));
        chk("txod_b", 128'(txod_b), 128'(m_txod));
        chk("rxod_b", 128'(rxod_b), 128'(m_rxod));
        chk("txv_a", 128'(txv_a), 128'(e_txv_a));
        chk("usv_a", 128'(usv_a), 128'(e_usv_a));
        chk("txv_b", 128'(txv_b), 128'(e_txv_b));
        chk("usv_b", 128'(usv_b), 128'(e_usv_b));
        for (int w = 0; w < A_CH * A_R; w++) begin
            chk("txd_a", txd_a[w*A_W +: A_W], e_txd_a[w*A_W +: A_W]);
            chk("usd_a", usd_a[w*A_W +: A_W], e_usd_a[w*A_W +: A_W]);
        end
        chk("txd_b", 128'(txd_b), 128'(e_txd_b));
        chk("usd_b", 128'(usd_b), 128'(e_usd_b));
        chk("dbg_a", 128'(dbg_a), 128'({12'h000, m_txod, m_rxod, 2'b00, ca}));
        chk("dbg_b", 128'(dbg_b), 128'({12'h000, m_txod, m_rxod, 2'b00, cb}));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!rst) compare_all();
        end
    endtask

    task automatic rnd_data();
        for (int k = 0; k < A_DW / 32; k++) begin
            dd_a[k*32 +: 32] = $urandom;
            rd_a[k*32 +: 32] = $urandom;
        end
        dd_b = 16'($urandom);
        rd_b = 16'($urandom);
    endtask

    task automatic set_valid(input logic [3:0] dv, input logic [3:0] rv);
        dv_a = dv; dv_b = dv[0];
        rv_a = rv; rv_b = rv[0];
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pat [12];
        pat = '{4'hF, 4'h1, 4'h8, 4'h5, 4'hA, 4'h0, 4'h3, 4'hC, 4'h6, 4'h9, 4'hF, 4'h2};
        n_vec = 0; n_err = 0;
        rst = 1'b1; tx_online = 1'b0; rx_online = 1'b0; holdoff = 1'b0;
        dx = 16'd5; dy = 16'd2; dz = 16'd3;
        dd_a = '0; rd_a = '0; dd_b = '0; rd_b = '0;
        set_valid(4'h0, 4'h0);
        repeat (3) @(negedge clk);
        // reset state
        chk("rst_mrk_a", 128'(mrk_a), 128'(0));
        chk("rst_txod_a", 128'(txod_a), 128'(0));
        chk("rst_dbg_a", 128'(dbg_a), 128'(0));
        chk("rst_txd_a", 128'(|txd_a), 128'(0));
        rst = 1'b0;
        step(2);

        // TX online after 1 + 5 + 1 edges, marker from the first edge
        tx_online = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            chk("x5_txod", 128'(txod_a), 128'(i >= 7));
            chk("x5_mrk", 128'(mrk_a), 128'(4'b1000));
        end
        // downstream traffic through the open gate, partial lanes
        for (int i = 0; i < 12; i++) begin
            rnd_data();
            set_valid(pat[i], 4'h0);
            step(1);
        end
        chk("hold_lane", txd_a[1*A_W +: A_W], e_txd_a[1*A_W +: A_W]);

        // drop, restart, drop at wait count 3, restart with full wait
        tx_online = 1'b0;
        step(1);
        chk("drop_mrk", 128'(mrk_a), 128'(0));
        chk("drop_txod", 128'(txod_a), 128'(0));
        step(1);
        tx_online = 1'b1;
        step(4);
        tx_online = 1'b0;
        step(1);
        chk("drop3_mrk", 128'(mrk_a), 128'(0));
        tx_online = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            rnd_data();
            step(1);
            chk("restart_txod", 128'(txod_b), 128'(i >= 7));
        end
        set_valid(4'h0, 4'h0);

        // RX with holdoff held, then released and re-applied
        holdoff = 1'b1; rx_online = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rnd_data();
            set_valid(4'h0, pat[i]);
            step(1);
            chk("hold_rxod", 128'(rxod_a), 128'(0));
        end
        holdoff = 1'b0;
        step(1);
        chk("release_rxod", 128'(rxod_a), 128'(1));
        for (int i = 0; i < 6; i++) begin
            rnd_data();
            set_valid(4'h0, pat[i + 3]);
            step(1);
        end
        holdoff = 1'b1;
        step(1);
        chk("reapply_rxod", 128'(rxod_a), 128'(0));
        holdoff = 1'b0;
        rnd_data();
        step(3);
        set_valid(4'h0, 4'h0);

        // both requests drop together, then rise together; periodic strobe
        tx_online = 1'b0; rx_online = 1'b0;
        step(2);
        tx_online = 1'b1; rx_online = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            rnd_data();
            set_valid(pat[i % 12], pat[(i + 5) % 12]);
            step(1);
            chk("stb_pulse", 128'(stb_b), 128'((i - 1) == 3 || (i - 1) == 19 || (i - 1) == 35));
            chk("stb_persist", 128'(stb_a), 128'((i - 1) >= 3));
        end

        // zero X delay: exactly one WAIT cycle
        set_valid(4'h0, 4'h0);
        tx_online = 1'b0;
        step(2);
        dx = 16'd0;
        tx_online = 1'b1;
        step(1);
        chk("x0_wait", 128'(txod_a), 128'(0));
        step(1);
        chk("x0_online", 128'(txod_a), 128'(1));
        rnd_data();
        set_valid(4'hF, 4'hF);
        step(3);

        // asynchronous reset in the middle of TX_ONLINE
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_txod_b", 128'(txod_b), 128'(0));
        chk("arst_rxod_b", 128'(rxod_b), 128'(0));
        chk("arst_mrk_b", 128'(mrk_b), 128'(0));
        chk("arst_stb_b", 128'(stb_b), 128'(0));
        chk("arst_txv_b", 128'(txv_b), 128'(0));
        chk("arst_usv_b", 128'(usv_b), 128'(0));
        chk("arst_txd_b", 128'(txd_b), 128'(0));
        chk("arst_usd_b", 128'(usd_b), 128'(0));
        chk("arst_dbg_b", 128'(dbg_b), 128'(0));
        chk("arst_txd_a", 128'(|txd_a), 128'(0));
        chk("arst_stb_a", 128'(stb_a), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_mrk_b", 128'(mrk_b), 128'(0));
        step(3);

        // traffic into closed gates after a fresh reset
        rst = 1'b1;
        tx_online = 1'b0; rx_online = 1'b0; dx = 16'd5;
        set_valid(4'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        set_valid(4'hF, 4'h0);
        for (int i = 0; i < 10; i++) begin
            rnd_data();
            step(1);
            chk("gated_txv", 128'(txv_a), 128'(0));
        end
        set_valid(4'h0, 4'h0);
`ifdef LPIF_ASYM_SYNC_DROP_CNT_EN
        chk("drop_cnt", 128'(dbg_a[15:0]), 128'(10));
`else
        chk("drop_cnt", 128'(dbg_a[15:0]), 128'(0));
`endif
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lpif_asym_sync_gate.md
LPIF_ASYM_SYNC_GATE -- requirements
Module: lpif_asym_sync_gate

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of PHY channels sharing the link (1..24).
REQ-002 SHALL have parameter RATIO, default 4, words per clk_wr (1 = full, 2 = half, 4 = quarter rate).
REQ-003 SHALL have parameter LANE_W, default 128, data bits per word.
REQ-004 SHALL have parameter PERSISTENT_STROBE, default 1: 1 = strobe every cycle; 0 = one pulse every 16 cycles.
REQ-005 SHALL have the following ports: clk_wr, input, 1, sole clock. The block uses one clock.
REQ-006 SHALL have rst_wr, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have the following inputs: tx_online (1, request TX online) and rx_online (1, remote link up).
REQ-008 SHALL have input rx_online_holdoff, 1, holds RX gating closed.
REQ-009 SHALL have inputs delay_x_value, delay_y_value and delay_z_value, each 16 bits: the TX online delay, RX online delay and strobe start delay, in clk_wr cycles.
REQ-010 SHALL have the following inputs: dstrm_data (NUM_CH*RATIO*LANE_W) and dstrm_valid (RATIO).
REQ-011 SHALL have outputs txg_data (NUM_CH*RATIO*LANE_W) and txg_valid (RATIO), the gated downstream data and valid.
REQ-012 SHALL have inputs rxp_data (NUM_CH*RATIO*LANE_W) and rxp_valid (RATIO), the raw upstream data and valid from the PHY side.
REQ-013 SHALL have outputs ustrm_data (NUM_CH*RATIO*LANE_W) and ustrm_valid (RATIO), the gated upstream data and valid.
REQ-014 SHALL have the following outputs: tx_auto_mrk_userbit (RATIO), tx_auto_stb_userbit (1), tx_online_delay (1), rx_online_delay (1) and debug_status (32).

Function
REQ-015 TX FSM states SHALL be TX_IDLE, TX_WAIT and TX_ONLINE.
REQ-016 TX FSM transitions SHALL be:
- TX_IDLE to TX_WAIT when tx_online=1.
- TX_WAIT to TX_ONLINE when the cycle counter equals delay_x_value.
- Any state to TX_IDLE the cycle after tx_online=0, with the counter cleared.
REQ-017 delay_x_value=0 SHALL give TX_WAIT for exactly one cycle.
REQ-018 tx_online_delay SHALL be 1 only in TX_ONLINE (registered).
REQ-019 The RX FSM SHALL have states RX_IDLE, RX_WAIT, RX_HOLD and RX_ONLINE.
REQ-020 RX FSM transitions SHALL be:
- RX_IDLE to RX_WAIT when rx_online=1.
- RX_WAIT to RX_HOLD when the counter equals delay_y_value.
- RX_HOLD to RX_ONLINE when rx_online_holdoff=0.
- RX_ONLINE to RX_HOLD when holdoff=1.
- rx_online=0 returns the FSM to RX_IDLE from any state.
REQ-021 rx_online_delay SHALL be 1 only in RX_ONLINE.
REQ-022 Markers: in TX_WAIT and TX_ONLINE, tx_auto_mrk_userbit[RATIO-1] SHALL be 1 every cycle and all other bits 0; in TX_IDLE all bits SHALL be 0.
REQ-023 Strobe: a strobe counter SHALL start on entry to TX_WAIT.
REQ-024 tx_auto_stb_userbit SHALL be 0 until the strobe counter reaches delay_z_value.
REQ-025 After the strobe counter reaches delay_z_value, tx_auto_stb_userbit SHALL be 1 every cycle if PERSISTENT_STROBE=1; otherwise it SHALL be 1 for one cycle every 16 cycles, with the first pulse at the counter match.
REQ-026 Gating: txg_valid SHALL equal dstrm_valid when tx_online_delay=1, else 0.
REQ-027 txg_data SHALL be registered and have 1-cycle latency, aligned with txg_valid.
REQ-028 ustrm_valid SHALL equal rxp_valid when rx_online_delay=1, else 0; ustrm_data SHALL be registered with 1-cycle latency.
REQ-029 Data registers SHALL load only on lanes with valid set and hold otherwise.
REQ-030 Delay counters SHALL be 16-bit and saturate at 16'hFFFF, never wrapping.
REQ-031 debug_status SHALL be {12'h0, tx_online_delay, rx_online_delay, 2'b0, cnt[15:0]}.
REQ-032 When tx_online and rx_online change in the same cycle, the two FSMs SHALL update independently, with no priority between them.

Reset
REQ-033 On rst_wr=1, both FSMs SHALL go to IDLE and all counters SHALL clear.
REQ-034 On rst_wr=1, all outputs SHALL be 0, including the data registers.
REQ-035 Reset assertion mid-operation SHALL take effect without a clock edge.
REQ-036 After reset release, the first transition SHALL occur no earlier than the first clk_wr edge.

Configuration
REQ-037 With macro LPIF_ASYM_SYNC_DROP_CNT_EN defined, cnt SHALL be a 16-bit saturating count of cycles in which any dstrm_valid or rxp_valid bit was set while its direction was gated.
REQ-038 With the macro defined, cnt SHALL clear on reset only.
REQ-039 Without the macro, cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-040 A shared package lpif_asym_pkg SHALL hold the TX and RX state enums, STB_PULSE_PERIOD=16 and DLY_W=16.
REQ-041 One sub-module, lpif_asym_dly_cnt (a saturating 16-bit delay counter with clear/enable/match), SHALL be instantiated three times: X, Y and Z.

Verification
REQ-042 Bench SHALL set delay_x_value=5 and raise tx_online at cycle 0; tx_online_delay SHALL rise at cycle 7 (1 to enter TX_WAIT, 5 counting, 1 registered), and tx_auto_mrk_userbit SHALL be 4'b1000 from cycle 1.
REQ-043 Bench SHALL drop tx_online at wait count 3 of 5; the FSM SHALL return to TX_IDLE the next cycle, the marker SHALL be 0, and a restart SHALL take the full 5 again.
REQ-044 Bench SHALL run rx_online=1 with delay_y_value=2 and holdoff=1 held; rx_online_delay SHALL stay 0. When holdoff is released it SHALL rise the next cycle; when holdoff is set again it SHALL fall the next cycle.
REQ-045 Bench SHALL run PERSISTENT_STROBE=0 with delay_z_value=3; strobe pulses SHALL occur at cycles 3, 19 and 35 after TX_WAIT entry and at no other time.
REQ-046 With LPIF_ASYM_SYNC_DROP_CNT_EN defined, bench SHALL drive dstrm_valid=4'hF for 10 cycles while gated; debug_status[15:0] SHALL read 10 and txg_valid SHALL stay 0.
REQ-047 Bench SHALL run NUM_CH=1, RATIO=1 and assert rst_wr asynchronously mid-TX_ONLINE; all outputs SHALL be 0 before the next edge.
